// File: rtl/famiclone_probe_if.sv
// Console-side PPU probe lines and detector status, bundled for the famiclone probe.
// master = stimulus/console side, slave = the detector itself.
interface famiclone_probe_if;
  logic       ppu_rd_in;
  logic       ppu_a13;
  logic       ppu_not_a13;
  logic [1:0] force_mode;
  logic       init_finished;
  logic       decided;
  logic       new_dendy;
  logic       ground_ciram_ce;
  logic       ground_not_a13;
  logic [1:0] state;

  modport master (
    output ppu_rd_in, ppu_a13, ppu_not_a13, force_mode,
    input  init_finished, decided, new_dendy, ground_ciram_ce, ground_not_a13, state
  );

  modport slave (
    input  ppu_rd_in, ppu_a13, ppu_not_a13, force_mode,
    output init_finished, decided, new_dendy, ground_ciram_ce, ground_not_a13, state
  );
endinterface

// File: rtl/famiclone_probe.sv
// Power-on console classifier: grounds CIRAM /CE and /A13 for a fixed hold time,
// then votes on PPU reads at both A13 levels to tell classic consoles from new famiclones.
module famiclone_probe #(
  parameter int HOLD_CYCLES  = 15,
  parameter int SAMPLES      = 3,
  parameter int MISMATCH_MIN = 2,
  parameter int TIMEOUT      = 65535,
  parameter int SYNC_STAGES  = 2
) (
  input  logic m2,
  input  logic rst_n,
  famiclone_probe_if.slave bus
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;
  localparam int SMP_W  = $clog2(SAMPLES) + 1;
  localparam int MIS_W  = $clog2(2 * SAMPLES) + 1;
  localparam int TO_W   = $clog2(TIMEOUT) + 1;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [SMP_W-1:0]  SMP_FULL  = SMP_W'(SAMPLES);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [31:0]       MIS_THR   = 32'(MISMATCH_MIN);

  // Synchroniser reset levels: bit0 = /RD (idle high), bit1 = A13, bit2 = /A13.
  localparam logic [2:0] SYNC_INIT = 3'b001;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'b00,
    ST_PROBE   = 2'b01,
    ST_DECIDED = 2'b10
  } state_t;

  logic [2:0] async_in;
  logic [2:0] synced;
  logic       rd_s;
  logic       a13_s;
  logic       na13_s;

  assign async_in = {bus.ppu_not_a13, bus.ppu_a13, bus.ppu_rd_in};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] chain_q;

      always_ff @(posedge m2 or negedge rst_n) begin
        if (!rst_n) begin
          chain_q <= {SYNC_STAGES{SYNC_INIT[gi]}};
        end else begin
          chain_q <= {chain_q[SYNC_STAGES-2:0], async_in[gi]};
        end
      end

      assign synced[gi] = chain_q[SYNC_STAGES-1];
    end
  endgenerate

  assign rd_s   = synced[0];
  assign a13_s  = synced[1];
  assign na13_s = synced[2];

  state_t              state_q, state_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [SMP_W-1:0]    lo_cnt_q, lo_cnt_d;
  logic [SMP_W-1:0]    hi_cnt_q, hi_cnt_d;
  logic [MIS_W-1:0]    mis_cnt_q, mis_cnt_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic                init_q, init_d;
  logic                decided_q, decided_d;
  logic                new_dendy_q, new_dendy_d;
  logic                ground_q, ground_d;
  logic                rd_prev_q;
  logic                a13_prev_q;

  logic sample_valid;
  logic levels_full;
  logic mis_enough;
  logic sample_mismatch;

  // A read counts only once /RD has been low for two cycles with A13 steady,
  // which rejects single-cycle /RD glitches and address transitions.
  assign sample_valid    = !rd_s && !rd_prev_q && (a13_s == a13_prev_q);
  assign sample_mismatch = (a13_s == na13_s);
  assign levels_full     = (lo_cnt_q == SMP_FULL) && (hi_cnt_q == SMP_FULL);
  assign mis_enough      = (32'(mis_cnt_q) >= MIS_THR);

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    lo_cnt_d    = lo_cnt_q;
    hi_cnt_d    = hi_cnt_q;
    mis_cnt_d   = mis_cnt_q;
    to_cnt_d    = to_cnt_q;
    init_d      = init_q;
    decided_d   = decided_q;
    new_dendy_d = new_dendy_q;
    ground_d    = ground_q;

    case (state_q)
      ST_HOLD: begin
        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        if (hold_cnt_q == HOLD_LAST) begin
          init_d   = 1'b1;
          ground_d = 1'b0;
          if ((bus.force_mode == 2'b01) || (bus.force_mode == 2'b10)) begin
            state_d     = ST_DECIDED;
            decided_d   = 1'b1;
            new_dendy_d = bus.force_mode[1];
          end else begin
            state_d = ST_PROBE;
          end
        end
      end

      ST_PROBE: begin
        // A completed vote takes priority over a coincident timeout.
        if (levels_full) begin
          state_d     = ST_DECIDED;
          decided_d   = 1'b1;
          new_dendy_d = mis_enough;
        end else if (to_cnt_q == TO_LAST) begin
          state_d     = ST_DECIDED;
          decided_d   = 1'b1;
          new_dendy_d = 1'b0;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
          if (sample_valid) begin
            if (a13_s) begin
              if (hi_cnt_q != SMP_FULL) begin
                hi_cnt_d = hi_cnt_q + SMP_W'(1);
                if (sample_mismatch) mis_cnt_d = mis_cnt_q + MIS_W'(1);
              end
            end else begin
              if (lo_cnt_q != SMP_FULL) begin
                lo_cnt_d = lo_cnt_q + SMP_W'(1);
                if (sample_mismatch) mis_cnt_d = mis_cnt_q + MIS_W'(1);
              end
            end
          end
        end
      end

      ST_DECIDED: begin
      end

      default: begin
        state_d = ST_HOLD;
      end
    endcase
  end

  always_ff @(posedge m2 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_HOLD;
      hold_cnt_q  <= '0;
      lo_cnt_q    <= '0;
      hi_cnt_q    <= '0;
      mis_cnt_q   <= '0;
      to_cnt_q    <= '0;
      init_q      <= 1'b0;
      decided_q   <= 1'b0;
      new_dendy_q <= 1'b0;
      ground_q    <= 1'b1;
      rd_prev_q   <= 1'b1;
      a13_prev_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      lo_cnt_q    <= lo_cnt_d;
      hi_cnt_q    <= hi_cnt_d;
      mis_cnt_q   <= mis_cnt_d;
      to_cnt_q    <= to_cnt_d;
      init_q      <= init_d;
      decided_q   <= decided_d;
      new_dendy_q <= new_dendy_d;
      ground_q    <= ground_d;
      rd_prev_q   <= rd_s;
      a13_prev_q  <= a13_s;
    end
  end

  assign bus.init_finished   = init_q;
  assign bus.decided         = decided_q;
  assign bus.new_dendy       = new_dendy_q;
  assign bus.ground_ciram_ce = ground_q;
  assign bus.ground_not_a13  = ground_q;
  assign bus.state           = state_q;

endmodule

// File: tb/tb_famiclone_probe.sv
// Randomised scoreboard bench for famiclone_probe: each run is a reset-to-verdict
// sequence whose expected init/decision edges and verdict come from a reference model.
module tb_famiclone_probe;

  localparam int H   = 15;
  localparam int SMP = 3;
  localparam int MIN = 2;
  localparam int TO  = 100;
  localparam int SS  = 2;
  localparam int N   = H + TO + SS + 12;

  logic m2 = 1'b0;
  logic rst_n = 1'b0;

  famiclone_probe_if bus();

  famiclone_probe #(
    .HOLD_CYCLES (H),
    .SAMPLES     (SMP),
    .MISMATCH_MIN(MIN),
    .TIMEOUT     (TO),
    .SYNC_STAGES (SS)
  ) dut (
    .m2   (m2),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 m2 = ~m2;

  typedef struct {
    int id;
    int init_edge;
    int dec_edge;
    bit nd;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   edge_n;

  bit         stim_rd   [N];
  bit         stim_a13  [N];
  bit         stim_na13 [N];
  logic [1:0] stim_fm   [N];

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Edge number since reset release: edge 1 is the first rising m2 edge with rst_n high.
  always @(posedge m2 or negedge rst_n) begin
    if (!rst_n) edge_n <= 0;
    else        edge_n <= edge_n + 1;
  end

  // Reference model: list the valid samples seen by the detector, find where both
  // levels first reach SAMPLES, and compare that against the timeout edge.
  function automatic exp_t model(input int id);
    exp_t       e;
    int         lo, hi, mis, done_edge, j;
    logic [1:0] fm;
    lo = 0; hi = 0; mis = 0; done_edge = -1;
    fm = stim_fm[H-1];
    e.id = id;
    e.init_edge = H;
    if (fm == 2'b01 || fm == 2'b10) begin
      e.dec_edge = H;
      e.nd = fm[1];
      return e;
    end
    for (int n = H + 1; n <= H + TO - 1; n++) begin
      j = n - SS - 1;
      if (!stim_rd[j] && !stim_rd[j-1] && stim_a13[j] == stim_a13[j-1]) begin
        if (stim_a13[j]) begin
          if (hi < SMP) begin
            hi++;
            if (stim_a13[j] == stim_na13[j]) mis++;
          end
        end else begin
          if (lo < SMP) begin
            lo++;
            if (stim_a13[j] == stim_na13[j]) mis++;
          end
        end
        if (lo == SMP && hi == SMP && done_edge < 0) done_edge = n;
      end
    end
    if (done_edge >= 0) begin
      e.dec_edge = done_edge + 1;
      e.nd = (mis >= MIN);
    end else begin
      e.dec_edge = H + TO;
      e.nd = 1'b0;
    end
    return e;
  endfunction

  // kind: 0 classic, 1 new famiclone, 2 mixed, 3 one level only, 4 glitches, 5 forced
  task automatic build(input int kind);
    logic [1:0] fm_sel;
    int         i, gap, len;
    bit         lv, mm, tog;
    if (kind == 5) fm_sel = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
    else           fm_sel = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
    for (int k = 0; k < N; k++) begin
      stim_rd[k]   = 1'b1;
      stim_a13[k]  = 1'($urandom_range(0, 1));
      stim_na13[k] = 1'($urandom_range(0, 1));
      stim_fm[k]   = (k <= H + 2) ? fm_sel : 2'($urandom_range(0, 3));
    end
    i = H + 1;
    lv = 1'($urandom_range(0, 1));
    while (i < N) begin
      gap = $urandom_range(1, 3);
      i += gap;
      tog = 1'b0;
      mm  = 1'b0;
      len = $urandom_range(2, 5);
      case (kind)
        0: lv = ~lv;
        1: begin lv = ~lv; mm = 1'b1; end
        3: begin lv = 1'b0; mm = 1'($urandom_range(0, 1)); end
        4: begin
          lv = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 1) == 1) len = 1;
          else tog = 1'b1;
        end
        default: begin
          len = $urandom_range(1, 5);
          lv  = 1'($urandom_range(0, 1));
          mm  = 1'($urandom_range(0, 1));
        end
      endcase
      for (int k = 0; k < len && i < N; k++) begin
        stim_rd[i]   = 1'b0;
        stim_a13[i]  = tog ? (lv ^ k[0]) : lv;
        stim_na13[i] = mm ? stim_a13[i] : ~stim_a13[i];
        i++;
      end
    end
  endtask

  task automatic drive(input int i);
    bus.ppu_rd_in   = stim_rd[i];
    bus.ppu_a13     = stim_a13[i];
    bus.ppu_not_a13 = stim_na13[i];
    bus.force_mode  = stim_fm[i];
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"},     bus.state, 0);
    check({tag, "_init"},      bus.init_finished, 0);
    check({tag, "_decided"},   bus.decided, 0);
    check({tag, "_new_dendy"}, bus.new_dendy, 0);
    check({tag, "_gnd_ce"},    bus.ground_ciram_ce, 1);
    check({tag, "_gnd_na13"},  bus.ground_not_a13, 1);
  endtask

  task automatic run(input int kind, input int id, input bit abort);
    exp_t e;
    build(kind);
    e = model(id);
    $display("run %0d kind=%0d abort=%0d exp_init=%0d exp_decide=%0d exp_new_dendy=%0d",
             id, kind, abort, e.init_edge, e.dec_edge, e.nd);
    exp_q.push_back(e);
    @(negedge m2); #2;
    drive(0);
    rst_n = 1'b1;
    @(negedge m2); #2;
    for (int i = 1; i < N; i++) begin
      drive(i);
      if (abort && i == H + 6) break;
      @(negedge m2); #2;
    end
    if (abort) begin
      check("abort_before_decision", exp_q.size(), 1);
      rst_n = 1'b0;
      #1;
      check_reset_values("midprobe_reset");
      exp_q.delete();
    end else begin
      check("decision_seen", exp_q.size(), 0);
      exp_q.delete();
      rst_n = 1'b0;
      #1;
      check_reset_values("decided_reset");
    end
  endtask

  // Monitor: compares DUT milestones against the front of the scoreboard queue.
  initial begin
    bit prev_init;
    bit prev_dec;
    bit held_nd;
    exp_t e;
    prev_init = 1'b0;
    prev_dec  = 1'b0;
    held_nd   = 1'b0;
    forever begin
      @(negedge m2);
      if (!rst_n) begin
        prev_init = 1'b0;
        prev_dec  = 1'b0;
      end else begin
        if (!bus.init_finished) begin
          check("hold_gnd_ce",   bus.ground_ciram_ce, 1);
          check("hold_gnd_na13", bus.ground_not_a13, 1);
          check("hold_decided",  bus.decided, 0);
        end
        if (bus.init_finished && !prev_init) begin
          if (exp_q.size() == 0) begin
            check("init_unexpected", 1, 0);
          end else begin
            check($sformatf("init_edge_run%0d", exp_q[0].id), edge_n, exp_q[0].init_edge);
            check("init_gnd_ce",   bus.ground_ciram_ce, 0);
            check("init_gnd_na13", bus.ground_not_a13, 0);
          end
        end
        if (bus.decided && !prev_dec) begin
          if (exp_q.size() == 0) begin
            check("decide_unexpected", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("decide_edge_run%0d", e.id), edge_n, e.dec_edge);
            check($sformatf("new_dendy_run%0d", e.id), bus.new_dendy, e.nd);
            check("decided_state", bus.state, 2);
            check("decided_init",  bus.init_finished, 1);
            check("decided_gnd",   bus.ground_ciram_ce | bus.ground_not_a13, 0);
            held_nd = e.nd;
          end
        end else if (bus.decided) begin
          check("sticky_new_dendy", bus.new_dendy, held_nd);
          check("sticky_state",     bus.state, 2);
        end else if (bus.init_finished) begin
          check("probe_state", bus.state, 1);
        end
        prev_init = bus.init_finished;
        prev_dec  = bus.decided;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks expected completion", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int id;
    bus.ppu_rd_in   = 1'b1;
    bus.ppu_a13     = 1'b0;
    bus.ppu_not_a13 = 1'b1;
    bus.force_mode  = 2'b00;
    rst_n = 1'b0;
    repeat (3) @(negedge m2);
    #2;
    check_reset_values("power_on");
    id = 0;
    run(0, id++, 1'b0);
    run(1, id++, 1'b0);
    run(3, id++, 1'b0);
    run(5, id++, 1'b0);
    run(0, id++, 1'b1);
    run(0, id++, 1'b0);
    run(4, id++, 1'b0);
    for (int r = 0; r < 24; r++) begin
      run($urandom_range(0, 5), id++, ($urandom_range(0, 7) == 0));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
